pixel_plot_sink: RTL and testbench

//  Receiving end of the pixel-plot interface (x, y, colour, plot) driven by the symbol drawers.

---
 rtl/pixel_plot_sink_pkg.sv | 22 ++
 rtl/pixel_plot_sink_fb_ram.sv | 39 +++
 rtl/pixel_plot_sink.sv | 161 ++++++++++++++++
 tb/tb_pixel_plot_sink.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_plot_sink_pkg.sv
// pixel_plot_sink_pkg
//   Shared definitions for the pixel-plot receiving end. It holds the default
//   framebuffer geometry, the FSM state encoding and a saturating counter helper.
package pixel_plot_sink_pkg;

    localparam int DEF_WIDTH  = 160;
    localparam int DEF_HEIGHT = 120;
    localparam int DEF_XW     = 8;
    localparam int DEF_YW     = 7;
    localparam int DEF_CW     = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1
    } state_t;

    // 8-bit increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pixel_plot_sink_fb_ram.sv
// fb_ram
//   Simple dual-port synchronous RAM with one write port and one read port.
//   A read and a write to the same address in the same cycle return the old
//   contents (read-before-write). The read register only updates when re is
//   high, so rdata holds between reads. Contents are not reset.
// Ports
//   clk    in   clock, rising edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable
//   raddr  in   read address
//   rdata  out  registered read data, one cycle after re
module fb_ram #(
    parameter int DEPTH = 19200,
    parameter int AW    = 15,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [CW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [CW-1:0] rdata
);

    logic [CW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pixel_plot_sink.sv
// pixel_plot_sink
//   Receiving end of the pixel-plot interface. It owns a WIDTH x HEIGHT
//   framebuffer, writes one plotted pixel per cycle, serves single-cycle-latency
//   read-backs and runs a fill engine that clears the buffer on command and
//   after reset.
// Handshake: plot, rd_req and clear_req are single-cycle strobes with no
//   backpressure. While busy is high, plot and rd_req are discarded and
//   clear_req is ignored. An accepted rd_req yields rd_valid exactly one cycle
//   later.
// Ports
//   clk, reset                  clock and synchronous active-high reset
//   plot, x, y, colour          pixel write strobe and payload
//   busy                        fill in progress
//   clear_req, clear_colour     start a fill with the given colour
//   clear_done                  one-cycle pulse after the last fill write
//   rd_req, rd_x, rd_y          read strobe and coordinates
//   rd_valid, rd_colour         read result; rd_colour holds between reads
//   drop_count                  saturating count of out-of-range plots
//   dbg_state                   current FSM state encoding
module pixel_plot_sink
    import pixel_plot_sink_pkg::*;
#(
    parameter int            WIDTH     = DEF_WIDTH,
    parameter int            HEIGHT    = DEF_HEIGHT,
    parameter int            XW        = DEF_XW,
    parameter int            YW        = DEF_YW,
    parameter int            CW        = DEF_CW,
    parameter logic [CW-1:0] BG_COLOUR = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          plot,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [CW-1:0] colour,
    output logic          busy,
    input  logic          clear_req,
    input  logic [CW-1:0] clear_colour,
    output logic          clear_done,
    input  logic          rd_req,
    input  logic [XW-1:0] rd_x,
    input  logic [YW-1:0] rd_y,
    output logic          rd_valid,
    output logic [CW-1:0] rd_colour,
    output logic [7:0]    drop_count,
    output logic [1:0]    dbg_state
);

    localparam int            DEPTH   = WIDTH * HEIGHT;
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [XW:0]   WIDTH_L = (XW + 1)'(WIDTH);
    localparam logic [YW:0]   HEIGHT_L = (YW + 1)'(HEIGHT);

    function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] px,
                                               input logic [YW-1:0] py);
        return AW'(py) * AW'(WIDTH) + AW'(px);
    endfunction

    state_t        state;
    logic [AW-1:0] fill_cnt;
    logic [CW-1:0] fill_colour;
    // Forces rd_colour to zero after reset and after an out-of-range read,
    // since the RAM read register is neither reset nor loaded for those.
    logic          rd_zero;

    logic          plot_in_range;
    logic          rd_in_range;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [CW-1:0] ram_wdata;
    logic          ram_re;
    logic [CW-1:0] ram_rdata;

    assign plot_in_range = ({1'b0, x} < WIDTH_L) && ({1'b0, y} < HEIGHT_L);
    assign rd_in_range   = ({1'b0, rd_x} < WIDTH_L) && ({1'b0, rd_y} < HEIGHT_L);

    // Write mux: the fill owns the port in CLEAR; in IDLE a clear_req
    // pre-empts a plot in the same cycle.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        if (state == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = fill_cnt;
            ram_wdata = fill_colour;
        end else if (state == ST_IDLE && plot && plot_in_range && !clear_req) begin
            ram_we    = 1'b1;
            ram_waddr = pix_addr(x, y);
            ram_wdata = colour;
        end
    end

    // Reads are served in IDLE even alongside a clear_req.
    assign ram_re = (state == ST_IDLE) && rd_req && rd_in_range;

    fb_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .CW    (CW)
    ) u_fb_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (pix_addr(rd_x, rd_y)),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_CLEAR;
            fill_cnt    <= '0;
            fill_colour <= BG_COLOUR;
            busy        <= 1'b1;
            clear_done  <= 1'b0;
            rd_valid    <= 1'b0;
            rd_zero     <= 1'b1;
            drop_count  <= 8'd0;
        end else begin
            clear_done <= 1'b0;
            rd_valid   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    rd_valid <= rd_req;
                    if (rd_req) begin
                        rd_zero <= !rd_in_range;
                    end
                    if (clear_req) begin
                        state       <= ST_CLEAR;
                        fill_cnt    <= '0;
                        fill_colour <= clear_colour;
                        busy        <= 1'b1;
                    end else if (plot && !plot_in_range) begin
                        drop_count <= sat_inc8(drop_count);
                    end
                end
                ST_CLEAR: begin
                    if (fill_cnt == LAST) begin
                        state      <= ST_IDLE;
                        fill_cnt   <= '0;
                        busy       <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_colour = rd_zero ? '0 : ram_rdata;
    assign dbg_state = state;

endmodule

// File: tb/tb_pixel_plot_sink.sv
// tb_pixel_plot_sink
//   Directed bench for pixel_plot_sink. The main instance uses a 4x3 buffer;
//   a second instance at the default 160x120 checks the full-size fill length
//   and drop counter saturation.
module tb_pixel_plot_sink;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // 4x3 instance
    logic       reset = 1'b1;
    logic       plot = 1'b0;
    logic [7:0] x = '0;
    logic [6:0] y = '0;
    logic [2:0] colour = '0;
    logic       busy;
    logic       clear_req = 1'b0;
    logic [2:0] clear_colour = '0;
    logic       clear_done;
    logic       rd_req = 1'b0;
    logic [7:0] rd_x = '0;
    logic [6:0] rd_y = '0;
    logic       rd_valid;
    logic [2:0] rd_colour;
    logic [7:0] drop_count;
    logic [1:0] dbg_state;

    // 160x120 instance
    logic       b_reset = 1'b1;
    logic       b_plot = 1'b0;
    logic [7:0] b_x = '0;
    logic       b_busy;
    logic       b_clear_done;
    logic       b_rd_valid;
    logic [2:0] b_rd_colour;
    logic [7:0] b_drop_count;
    logic [1:0] b_dbg_state;

    int tests  = 0;
    int failed = 0;

    logic [2:0] fb_model [12];

    pixel_plot_sink #(.WIDTH(4), .HEIGHT(3), .XW(8), .YW(7), .CW(3), .BG_COLOUR(3'b000)) dut (
        .clk          (clk),
        .reset        (reset),
        .plot         (plot),
        .x            (x),
        .y            (y),
        .colour       (colour),
        .busy         (busy),
        .clear_req    (clear_req),
        .clear_colour (clear_colour),
        .clear_done   (clear_done),
        .rd_req       (rd_req),
        .rd_x         (rd_x),
        .rd_y         (rd_y),
        .rd_valid     (rd_valid),
        .rd_colour    (rd_colour),
        .drop_count   (drop_count),
        .dbg_state    (dbg_state)
    );

    pixel_plot_sink dut_big (
        .clk          (clk),
        .reset        (b_reset),
        .plot         (b_plot),
        .x            (b_x),
        .y            (7'd0),
        .colour       (3'b111),
        .busy         (b_busy),
        .clear_req    (1'b0),
        .clear_colour (3'b000),
        .clear_done   (b_clear_done),
        .rd_req       (1'b0),
        .rd_x         (8'd0),
        .rd_y         (7'd0),
        .rd_valid     (b_rd_valid),
        .rd_colour    (b_rd_colour),
        .drop_count   (b_drop_count),
        .dbg_state    (b_dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_plot(input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
        plot = 1'b1; x = px; y = py; colour = pc;
        step();
        plot = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [7:0] px, input logic [6:0] py,
                           input logic [2:0] exp);
        rd_req = 1'b1; rd_x = px; rd_y = py;
        step();
        rd_req = 1'b0;
        check({tag, " rd_valid"}, 32'(rd_valid), 32'd1);
        check({tag, " rd_colour"}, 32'(rd_colour), 32'(exp));
    endtask

    task automatic check_all(input string tag);
        for (int yy = 0; yy < 3; yy++) begin
            for (int xx = 0; xx < 4; xx++) begin
                do_read($sformatf("%s (%0d,%0d)", tag, xx, yy), 8'(xx), 7'(yy), fb_model[yy*4+xx]);
            end
        end
    endtask

    task automatic fill_model(input logic [2:0] c);
        for (int i = 0; i < 12; i++) fb_model[i] = c;
    endtask

    // Called in the first busy cycle of a fill; expects clear_done in cycle 13.
    task automatic wait_fill(input string tag);
        int n;
        n = 1;
        while (!clear_done && n < 40) begin
            check($sformatf("%s busy c%0d", tag, n), 32'(busy), 32'd1);
            step();
            n++;
        end
        check({tag, " clear_done"}, 32'(clear_done), 32'd1);
        check({tag, " done cycle"}, 32'(n), 32'd13);
        check({tag, " busy low"}, 32'(busy), 32'd0);
        check({tag, " state idle"}, 32'(dbg_state), 32'd0);
        step();
        check({tag, " done single"}, 32'(clear_done), 32'd0);
    endtask

    initial begin
        int n;

        // 1. Reset and post-reset fill
        step();
        reset = 1'b0;
        check("rst busy", 32'(busy), 32'd1);
        check("rst clear_done", 32'(clear_done), 32'd0);
        check("rst rd_valid", 32'(rd_valid), 32'd0);
        check("rst rd_colour", 32'(rd_colour), 32'd0);
        check("rst drop_count", 32'(drop_count), 32'd0);
        check("rst state", 32'(dbg_state), 32'd1);
        wait_fill("t1");
        fill_model(3'b000);
        check_all("t1");
        step();
        check("t1 rd_valid idle", 32'(rd_valid), 32'd0);

        // 2. Plot then read
        do_plot(8'd2, 7'd1, 3'b101);
        fb_model[1*4+2] = 3'b101;
        do_read("t2", 8'd2, 7'd1, 3'b101);
        step();
        check("t2 rd_valid drop", 32'(rd_valid), 32'd0);
        check("t2 rd_colour hold", 32'(rd_colour), 32'd5);

        // 3. Same-cycle plot and read return the old colour
        plot = 1'b1; x = 8'd1; y = 7'd0; colour = 3'b011;
        do_read("t3 rbw", 8'd1, 7'd0, 3'b000);
        plot = 1'b0;
        fb_model[1] = 3'b011;
        do_read("t3 reread", 8'd1, 7'd0, 3'b011);

        // Back-to-back reads: one result per cycle
        rd_req = 1'b1; rd_x = 8'd2; rd_y = 7'd1;
        step();
        check("b2b r1 valid", 32'(rd_valid), 32'd1);
        check("b2b r1 colour", 32'(rd_colour), 32'd5);
        rd_x = 8'd1; rd_y = 7'd0;
        step();
        rd_req = 1'b0;
        check("b2b r2 valid", 32'(rd_valid), 32'd1);
        check("b2b r2 colour", 32'(rd_colour), 32'd3);

        // 4. Out-of-range plots and reads
        do_plot(8'd4, 7'd0, 3'b111);
        do_plot(8'd0, 7'd3, 3'b111);
        check("t4 drop_count", 32'(drop_count), 32'd2);
        check_all("t4");
        do_read("t4 oob read", 8'd4, 7'd0, 3'b000);

        // 5. Commanded clear; same-cycle plot is dropped uncounted, read is served
        clear_req = 1'b1; clear_colour = 3'b110;
        plot = 1'b1; x = 8'd9; y = 7'd9; colour = 3'b001;
        do_read("t5 read on clear", 8'd2, 7'd1, 3'b101);
        clear_req = 1'b0; clear_colour = 3'b000;
        plot = 1'b0;
        check("t5 busy", 32'(busy), 32'd1);
        check("t5 drop unchanged", 32'(drop_count), 32'd2);
        n = 1;
        // Plots while busy: one in range, one out of range
        do_plot(8'd0, 7'd0, 3'b001);
        n++;
        do_plot(8'd5, 7'd0, 3'b001);
        n++;
        rd_req = 1'b1; rd_x = 8'd0; rd_y = 7'd0;
        step();
        rd_req = 1'b0;
        n++;
        check("t5 rd ignored", 32'(rd_valid), 32'd0);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        n++;
        while (!clear_done && n < 40) begin
            step();
            n++;
        end
        check("t5 clear_done", 32'(clear_done), 32'd1);
        check("t5 done cycle", 32'(n), 32'd13);
        check("t5 drop busy", 32'(drop_count), 32'd2);
        fill_model(3'b110);
        check_all("t5");

        // 6. Reset at fill cycle 5 restarts the fill with the background colour
        clear_req = 1'b1; clear_colour = 3'b010;
        step();
        clear_req = 1'b0;
        for (int i = 1; i < 5; i++) step();
        check("t6 busy c5", 32'(busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6 drop reset", 32'(drop_count), 32'd0);
        wait_fill("t6");
        fill_model(3'b000);
        check_all("t6");

        // Full-size instance: fill length and drop counter saturation
        step();
        b_reset = 1'b0;
        n = 1;
        while (!b_clear_done && n < 20000) begin
            step();
            n++;
        end
        check("big clear_done", 32'(b_clear_done), 32'd1);
        check("big done cycle", 32'(n), 32'd19201);
        check("big busy", 32'(b_busy), 32'd0);
        b_plot = 1'b1; b_x = 8'd200;
        for (int i = 0; i < 254; i++) step();
        check("big drop 254", 32'(b_drop_count), 32'd254);
        for (int i = 0; i < 46; i++) step();
        b_plot = 1'b0;
        check("big drop sat", 32'(b_drop_count), 32'd255);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
